latch_bank_ctrl: RTL and testbench

LATCH_BANK_CTRL -- requirements
Module: latch_bank_ctrl

---
 rtl/latch_ctrl_pkg.sv | 18 +
 rtl/rr_arb2.sv | 29 ++
 rtl/latch_bank_ctrl.sv | 178 +++++++++++++++++
 tb/tb_latch_bank_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types and defaults for the SR latch bank write controller.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  localparam int PULSE_DEF  = 2;
  localparam int SETTLE_DEF = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  // Reset value makes req0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Serialises set/reset writes from two requesters onto an SR latch bank
// and verifies each write by reading the latch back.
//
// state     | meaning
// ST_IDLE   | waiting for a request, ready offered to the arbitration winner
// ST_DRIVE  | one-hot set or reset pulse on the target latch, PULSE cycles
// ST_SETTLE | all latch inputs low, SETTLE cycles
// ST_CHECK  | compare readback, pulse done (and err on mismatch)
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int N      = 8,
  parameter int PULSE  = PULSE_DEF,
  parameter int SETTLE = SETTLE_DEF,
  // One spare code point so out-of-range indices are expressible when N is a power of two.
  localparam int IDX_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic             req0_val,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IDX_W-1:0] req1_idx,
  input  logic             req1_val,
  output logic             req1_ready,
  output logic [N-1:0]     lat_s,
  output logic [N-1:0]     lat_r,
  input  logic [N-1:0]     lat_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             done_id
);

  localparam int                CNT_W     = $clog2(max2(PULSE, SETTLE) + 1);
  localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]  N_IDX     = IDX_W'(N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             val_q, val_d;
  logic             own_q, own_d;
  logic [N-1:0]     lat_s_q, lat_s_d;
  logic [N-1:0]     lat_r_q, lat_r_d;
  logic             armed_q;

  logic [1:0]       arb_req;
  logic [1:0]       grant;
  logic             accept;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_val;
  logic [N-1:0]     sel_hot;
  logic             q_bit;
  logic             in_range;

  // armed_q holds off ready until the first clock edge after reset release.
  assign arb_req = {req1_valid, req0_valid} & {2{(state_q == ST_IDLE) && armed_q}};
  assign accept  = |grant;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .accept (accept),
    .grant  (grant)
  );

  assign sel_idx = grant[1] ? req1_idx : req0_idx;
  assign sel_val = grant[1] ? req1_val : req0_val;

  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == IDX_W'(i)) sel_hot[i] = 1'b1;
    end
  end

  // Readback is only looked at while checking.
  always_comb begin
    q_bit = 1'b0;
    if (state_q == ST_CHECK) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IDX_W'(i)) q_bit = lat_q[i];
      end
    end
  end

  assign in_range = (idx_q < N_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    own_d   = own_q;
    lat_s_d = '0;
    lat_r_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d = sel_idx;
          val_d = sel_val;
          own_d = grant[1];
          if (sel_idx < N_IDX) begin
            state_d = ST_DRIVE;
            cnt_d   = PULSE_LD;
            lat_s_d = sel_hot & {N{sel_val}};
            lat_r_d = sel_hot & {N{~sel_val}};
          end else begin
            state_d = ST_CHECK;
            cnt_d   = '0;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          lat_s_d = lat_s_q;
          lat_r_d = lat_r_q;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= 1'b0;
      own_q   <= 1'b0;
      lat_s_q <= '0;
      lat_r_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      own_q   <= own_d;
      lat_s_q <= lat_s_d;
      lat_r_q <= lat_r_d;
      armed_q <= 1'b1;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign lat_s      = lat_s_q;
  assign lat_r      = lat_r_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_CHECK);
  assign err        = done && (!in_range || (q_bit != val_q));
  assign done_id    = done && own_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed bench for latch_bank_ctrl with a transaction-level reference model.
module tb_latch_bank_ctrl;

  localparam int N      = 8;
  localparam int PULSE  = 2;
  localparam int SETTLE = 1;
  localparam int IDX_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [IDX_W-1:0] req0_idx = '0, req1_idx = '0;
  logic             req0_val = 1'b0, req1_val = 1'b0;
  logic             req0_ready, req1_ready;
  logic [N-1:0]     lat_s, lat_r, lat_q;
  logic             busy, done, err, done_id;

  logic [N-1:0]     bank = '0;
  logic [N-1:0]     stuck0 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  latch_bank_ctrl #(.N(N), .PULSE(PULSE), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_idx   (req0_idx),
    .req0_val   (req0_val),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_idx   (req1_idx),
    .req1_val   (req1_val),
    .req1_ready (req1_ready),
    .lat_s      (lat_s),
    .lat_r      (lat_r),
    .lat_q      (lat_q),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .done_id    (done_id)
  );

  always #5 clk = ~clk;

  // Behavioural SR latch bank, with optional stuck-at-0 readback bits.
  always @(lat_s or lat_r) begin
    for (int i = 0; i < N; i++) begin
      if (lat_s[i]) bank[i] = 1'b1;
      else if (lat_r[i]) bank[i] = 1'b0;
    end
  end
  assign lat_q = bank & ~stuck0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one write is a transaction of m_len busy cycles after acceptance.
  bit m_active, m_armed, m_ptr, m_val, m_own, m_w;
  int m_t, m_len, m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_armed = 0; m_ptr = 1; m_val = 0; m_own = 0;
      m_t = 0; m_len = 0; m_idx = 0;
    end else begin
      if (m_active) begin
        if (m_t == m_len) m_active = 0;
        else m_t++;
      end else if (m_armed && (req0_valid || req1_valid)) begin
        m_w      = (req0_valid && req1_valid) ? !m_ptr : req1_valid;
        m_ptr    = m_w;
        m_own    = m_w;
        m_idx    = m_w ? int'(req1_idx) : int'(req0_idx);
        m_val    = m_w ? req1_val : req0_val;
        m_len    = (m_idx < N) ? PULSE + SETTLE + 1 : 1;
        m_t      = 1;
        m_active = 1;
      end
      m_armed = 1;
    end
  end

  logic [N-1:0] e_s, e_r;
  bit e_r0, e_r1, e_done, e_err, e_id;

  always @(negedge clk) begin
    e_r0 = 0; e_r1 = 0;
    if (!m_active && m_armed && (req0_valid || req1_valid)) begin
      if (req0_valid && req1_valid) begin
        e_r0 = m_ptr; e_r1 = !m_ptr;
      end else begin
        e_r0 = req0_valid; e_r1 = req1_valid;
      end
    end
    e_s = '0; e_r = '0;
    if (m_active && m_idx < N && m_t <= PULSE) begin
      if (m_val) e_s[m_idx] = 1'b1;
      else e_r[m_idx] = 1'b1;
    end
    e_done = m_active && (m_t == m_len);
    e_err  = e_done && ((m_idx >= N) || (m_val && stuck0[m_idx % N]));
    e_id   = e_done && m_own;
    chk("cyc_ready0", 32'(req0_ready), 32'(e_r0));
    chk("cyc_ready1", 32'(req1_ready), 32'(e_r1));
    chk("cyc_busy", 32'(busy), 32'(m_active));
    chk("cyc_lat_s", 32'(lat_s), 32'(e_s));
    chk("cyc_lat_r", 32'(lat_r), 32'(e_r));
    chk("cyc_done", 32'(done), 32'(e_done));
    chk("cyc_err", 32'(err), 32'(e_err));
    chk("cyc_done_id", 32'(done_id), 32'(e_id));
    chk("cyc_s_and_r", 32'(lat_s & lat_r), 32'(0));
    chk("cyc_onehot0", 32'($onehot0(lat_s | lat_r)), 32'(1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk(name, 32'(seen), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int gq[$];
  int exp_ord[3] = '{0, 1, 0};

  initial begin
    repeat (3) tick();
    samp();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_lat_s", 32'(lat_s), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Set latch 3 from req0.
    req0_valid = 1; req0_idx = 4'd3; req0_val = 1;
    samp(); chk("t1_ready0", 32'(req0_ready), 32'(1));
    tick(); req0_valid = 0;
    samp(); chk("t1_lat_s_c1", 32'(lat_s), 32'h08);
    tick(); samp(); chk("t1_lat_s_c2", 32'(lat_s), 32'h08);
    tick(); samp(); chk("t1_lat_s_c3", 32'(lat_s), 32'h00);
    tick(); samp();
    chk("t1_done_c4", 32'(done), 32'(1));
    chk("t1_err", 32'(err), 32'(0));
    tick(); samp();
    chk("t1_lat_q3", 32'(lat_q[3]), 32'(1));
    chk("t1_idle", 32'(busy), 32'(0));

    // Reset latch 3 from req1.
    tick();
    req1_valid = 1; req1_idx = 4'd3; req1_val = 0;
    samp(); chk("t2_ready1", 32'(req1_ready), 32'(1));
    tick(); req1_valid = 0;
    samp(); chk("t2_lat_r_c1", 32'(lat_r), 32'h08);
    tick(); samp(); chk("t2_lat_r_c2", 32'(lat_r), 32'h08);
    tick(); tick(); samp();
    chk("t2_done_c4", 32'(done), 32'(1));
    chk("t2_done_id", 32'(done_id), 32'(1));
    chk("t2_err", 32'(err), 32'(0));
    chk("t2_lat_q3", 32'(lat_q[3]), 32'(0));

    // Both requesters held valid for three writes.
    tick();
    req0_valid = 1; req0_idx = 4'd1; req0_val = 1;
    req1_valid = 1; req1_idx = 4'd2; req1_val = 1;
    for (int c = 0; c < 40 && gq.size() < 3; c++) begin
      samp();
      if (req0_ready) gq.push_back(0);
      else if (req1_ready) gq.push_back(1);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("t3_grant_count", 32'(gq.size()), 32'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < gq.size()) chk("t3_grant_order", 32'(gq[i]), 32'(exp_ord[i]));
    end
    wait_done("t3_last_done");
    chk("t3_last_id", 32'(done_id), 32'(0));

    // Stuck-at-0 readback on latch 5.
    tick();
    stuck0 = 8'h20;
    req0_valid = 1; req0_idx = 4'd5; req0_val = 1;
    tick(); req0_valid = 0;
    tick(); tick(); tick(); samp();
    chk("t4_done", 32'(done), 32'(1));
    chk("t4_err", 32'(err), 32'(1));
    tick();
    stuck0 = '0;

    // Out-of-range index.
    req1_valid = 1; req1_idx = 4'd9; req1_val = 1;
    samp(); chk("t5_ready1", 32'(req1_ready), 32'(1));
    tick(); req1_valid = 0;
    samp();
    chk("t5_done", 32'(done), 32'(1));
    chk("t5_err", 32'(err), 32'(1));
    chk("t5_lat", 32'(lat_s | lat_r), 32'(0));
    tick(); samp(); chk("t5_idle", 32'(busy), 32'(0));

    // Reset during the second DRIVE cycle.
    tick();
    req0_valid = 1; req0_idx = 4'd4; req0_val = 1;
    tick(); req0_valid = 0;
    samp(); chk("t6_lat_s_c1", 32'(lat_s), 32'h10);
    tick();
    rst_n = 0;
    #1;
    chk("t6_async_lat_s", 32'(lat_s), 32'(0));
    chk("t6_async_lat_r", 32'(lat_r), 32'(0));
    chk("t6_async_busy", 32'(busy), 32'(0));
    tick(); tick();
    rst_n = 1;
    req0_valid = 1; req0_idx = 4'd6; req0_val = 1;
    req1_valid = 1; req1_idx = 4'd7; req1_val = 1;
    samp();
    chk("t6_no_early_ready0", 32'(req0_ready), 32'(0));
    chk("t6_no_early_ready1", 32'(req1_ready), 32'(0));
    chk("t6_no_done", 32'(done), 32'(0));
    tick(); samp();
    chk("t6_tie_ready0", 32'(req0_ready), 32'(1));
    chk("t6_tie_ready1", 32'(req1_ready), 32'(0));
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_done("t6_done");
    chk("t6_done_id", 32'(done_id), 32'(0));
    tick(); samp();
    chk("t6_idle", 32'(busy), 32'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
